count_free_serializer: RTL

Upstream feeder for `count_free`. Accepts a parallel `WIDTH`-bit word through a valid/ready handshake and drives it LSB-first onto `count_free`'s `start_req_i`/`start_data_i` pair. Each bit is held for `BIT_HOLD` cycles. After the word is sent, the block waits until `count_free` has raised and then dropped `busy_o` (result consumed) before it accepts the next word.

---
 rtl/count_free_serializer_pkg.sv | 25 ++
 rtl/count_free_serializer_bit_hold_timer.sv | 40 ++++
 rtl/count_free_serializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/count_free_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_free_serializer_pkg
// Brief    : Shared state encodings, default sizes and counter-width helper
//            for the count_free serializer front end.
// Revision : 1.0 - initial release
// ============================================================================
package count_free_serializer_pkg;

    localparam int CFS_DEF_WIDTH    = 4;
    localparam int CFS_DEF_BIT_HOLD = 10;

    typedef logic [1:0] cfs_state_t;

    localparam cfs_state_t CFS_IDLE  = 2'd0;
    localparam cfs_state_t CFS_SHIFT = 2'd1;
    localparam cfs_state_t CFS_WAIT  = 2'd2;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int cfs_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_free_serializer_bit_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : bit_hold_timer
// Brief    : Counts BIT_HOLD enabled cycles per serial bit; tick marks the
//            last cycle of each hold period.
// Revision : 1.0 - initial release
// ============================================================================
module bit_hold_timer
    import count_free_serializer_pkg::*;
#(
    parameter int BIT_HOLD = CFS_DEF_BIT_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                 c_cnt_w = cfs_cnt_width(BIT_HOLD);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BIT_HOLD - 1);

    logic [c_cnt_w-1:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_hold_cnt <= '0;
        end else if (en) begin
            if (r_hold_cnt == c_last) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign tick = (r_hold_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/count_free_serializer.sv
`default_nettype none
// ============================================================================
// Module   : count_free_serializer
// Brief    : Accepts a parallel word and drives it LSB-first, BIT_HOLD cycles
//            per bit, onto count_free's start pair; waits for its busy pulse.
// Revision : 1.0 - initial release
// ============================================================================
module count_free_serializer
    import count_free_serializer_pkg::*;
#(
    parameter int WIDTH    = CFS_DEF_WIDTH,
    parameter int BIT_HOLD = CFS_DEF_BIT_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             start_req_o,
    output logic             start_data_o,
    input  logic             busy_i,
    output logic             busy_o
);

    localparam int                 c_bit_w    = cfs_cnt_width(WIDTH);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(WIDTH - 1);

    cfs_state_t         r_state,     w_state_nxt;
    logic [WIDTH-1:0]   r_shreg,     w_shreg_nxt;
    logic [c_bit_w-1:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic               r_seen_busy, w_seen_busy_nxt;
    logic               w_tick;
    logic               w_timer_clr;

    // Timer is held cleared outside SHIFT so every word starts a fresh period.
    assign w_timer_clr = (r_state != CFS_SHIFT);

    bit_hold_timer #(
        .BIT_HOLD (BIT_HOLD)
    ) u_bit_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (w_timer_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CFS_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_seen_busy <= 1'b0;
        end else if (en) begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_seen_busy <= w_seen_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_seen_busy_nxt = r_seen_busy;
        case (r_state)
            CFS_IDLE: begin
                if (valid_i) begin
                    w_shreg_nxt     = data_i;
                    w_bit_cnt_nxt   = '0;
                    w_seen_busy_nxt = 1'b0;
                    w_state_nxt     = CFS_SHIFT;
                end
            end
            CFS_SHIFT: begin
                if (busy_i) begin
                    w_seen_busy_nxt = 1'b1;
                end
                if (w_tick) begin
                    w_shreg_nxt = r_shreg >> 1;
                    // Bit counter parks on its terminal value instead of wrapping.
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt = CFS_WAIT;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            CFS_WAIT: begin
                if (busy_i) begin
                    w_seen_busy_nxt = 1'b1;
                end
                if (r_seen_busy && !busy_i) begin
                    w_state_nxt = CFS_IDLE;
                end
            end
            default: begin
                w_state_nxt = CFS_IDLE;
            end
        endcase
    end

    assign ready_o      = (r_state == CFS_IDLE);
    assign busy_o       = (r_state != CFS_IDLE);
    assign start_req_o  = (r_state == CFS_SHIFT);
    assign start_data_o = (r_state == CFS_SHIFT) && r_shreg[0];

endmodule
`default_nettype wire
